// File: rtl/kypd_pkg.sv
// Shared keypad note controller definitions: key codes, base divider table,
// FSM state encoding.
package kypd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_HELD,
      ST_REL_DEB
   } kypd_state_e;

   localparam logic [3:0] KEY_REST   = 4'h0;
   localparam logic [3:0] KEY_OCT_DN = 4'hD;
   localparam logic [3:0] KEY_OCT_UP = 4'hE;
   localparam logic [3:0] KEY_NOISE  = 4'hF;

   // Divider restored on reset and used by the rest key (code 8 value).
   localparam logic [7:0] BASE_RESET = 8'd128;

   function automatic logic is_note(input logic [3:0] code);
      return (code != KEY_REST) && (code < KEY_OCT_DN);
   endfunction

   // Keys are laid out chromatically as 1 2 3 A 4 5 6 B 7 8 9 C.
   function automatic logic [7:0] base_div(input logic [3:0] code);
      logic [7:0] div;
      case (code)
         4'h1:    div = 8'd215;
         4'h2:    div = 8'd204;
         4'h3:    div = 8'd191;
         4'hA:    div = 8'd181;
         4'h4:    div = 8'd171;
         4'h5:    div = 8'd161;
         4'h6:    div = 8'd152;
         4'hB:    div = 8'd144;
         4'h7:    div = 8'd136;
         4'h8:    div = 8'd128;
         4'h9:    div = 8'd121;
         4'hC:    div = 8'd114;
         default: div = 8'd0;
      endcase
      return div;
   endfunction

endpackage

// File: rtl/evt_skid1.sv
// One-entry event buffer with valid/ready output. A push always wins; pushing
// into a full entry that is not draining flags a one-cycle overrun.
module evt_skid1 #(
   parameter int W = 17
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o,
   output logic         overrun_o
);

   logic         valid_q;
   logic [W-1:0] data_q;
   logic         ovr_q;

   // Entry register: load on push, empty on a completed transfer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= push_i && valid_q && !ready_i;
         if (push_i) begin
            valid_q <= 1'b1;
            data_q  <= push_data_i;
         end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign valid_o   = valid_q;
   assign data_o    = data_q;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/kypd_note_ctrl.sv
// Keypad note controller: debounces key presses and releases, maps keys to a
// tone divider with octave shift and noise mode, and emits note on/off events.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | no key accepted; a press latches its code
// ST_DEBOUNCE | counting cycles with the latched code stable
// ST_HELD     | key accepted and still pressed; code changes ignored
// ST_REL_DEB  | key released; counting stable release cycles
module kypd_note_ctrl
   import kypd_pkg::*;
#(
   parameter int          DIV_W      = 16,
   parameter int unsigned DEB_CYCLES = 16'd1000,
   parameter int          OCT_MAX    = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [3:0]       key_value_i,
   input  logic             key_valid_i,
   output logic [DIV_W-1:0] div_factor_o,
   output logic             gate_o,
   output logic             noise_en_o,
   output logic [2:0]       octave_o,
   output logic             evt_valid_o,
   input  logic             evt_ready_i,
   output logic             evt_gate_o,
   output logic [DIV_W-1:0] evt_div_o,
   output logic             overrun_o
);

   localparam int                CNT_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic signed [2:0] OCT_HI   = 3'(OCT_MAX);
   localparam logic signed [2:0] OCT_LO   = -OCT_HI;

   kypd_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        code_q, code_d;
   logic [7:0]        base_q, base_d;
   logic signed [2:0] oct_q, oct_d;
   logic              gate_q, gate_d;
   logic              noise_q, noise_d;

   logic              evt_push;
   logic [DIV_W:0]    evt_push_data;
   logic [DIV_W:0]    evt_data;

   // Octave shift of an 8-bit base; three guard bits catch left-shift overflow.
   function automatic logic [DIV_W-1:0] calc_div(input logic [7:0] base,
                                                 input logic signed [2:0] oct);
      logic [DIV_W+2:0] wide;
      logic [2:0]       mag;
      mag  = oct[2] ? (~oct + 3'd1) : oct;
      wide = {{(DIV_W-5){1'b0}}, base};
      if (oct[2]) begin
         wide = wide << mag;
         if (|wide[DIV_W+2:DIV_W]) return '1;
         return wide[DIV_W-1:0];
      end
      wide = wide >> mag;
      return wide[DIV_W-1:0];
   endfunction

   assign div_factor_o = calc_div(base_q, oct_q);
   assign gate_o       = gate_q;
   assign noise_en_o   = noise_q;
   assign octave_o     = oct_q;

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         code_q  <= KEY_REST;
         base_q  <= BASE_RESET;
         oct_q   <= '0;
         gate_q  <= 1'b0;
         noise_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         base_q  <= base_d;
         oct_q   <= oct_d;
         gate_q  <= gate_d;
         noise_q <= noise_d;
      end
   end

   // Debounce sequencing, key actions and event generation.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      code_d        = code_q;
      base_d        = base_q;
      oct_d         = oct_q;
      gate_d        = gate_q;
      noise_d       = noise_q;
      evt_push      = 1'b0;
      evt_push_data = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (key_valid_i) begin
               code_d  = key_value_i;
               cnt_d   = '0;
               state_d = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (!key_valid_i || (key_value_i != code_q)) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HELD;
               if (is_note(code_q)) begin
                  base_d        = base_div(code_q);
                  gate_d        = 1'b1;
                  noise_d       = 1'b0;
                  evt_push      = 1'b1;
                  evt_push_data = {1'b1, calc_div(base_div(code_q), oct_q)};
               end else begin
                  case (code_q)
                     KEY_OCT_DN: if (oct_q > OCT_LO) oct_d = oct_q - 3'sd1;
                     KEY_OCT_UP: if (oct_q < OCT_HI) oct_d = oct_q + 3'sd1;
                     KEY_NOISE:  noise_d = !noise_q;
                     KEY_REST: begin
                        base_d  = BASE_RESET;
                        noise_d = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (!key_valid_i) begin
               cnt_d   = '0;
               state_d = ST_REL_DEB;
            end
         end
         ST_REL_DEB: begin
            if (key_valid_i) begin
               state_d = ST_HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               if (is_note(code_q)) begin
                  gate_d        = 1'b0;
                  evt_push      = 1'b1;
                  evt_push_data = {1'b0, div_factor_o};
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   evt_skid1 #(
      .W (DIV_W + 1)
   ) u_evt_skid1 (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (evt_push),
      .push_data_i (evt_push_data),
      .valid_o     (evt_valid_o),
      .ready_i     (evt_ready_i),
      .data_o      (evt_data),
      .overrun_o   (overrun_o)
   );

   assign evt_gate_o = evt_data[DIV_W];
   assign evt_div_o  = evt_data[DIV_W-1:0];

endmodule

// File: tb/tb_kypd_note_ctrl.sv
// Bench for kypd_note_ctrl: directed press/release scenarios followed by random
// key sessions, checked against a press-level behavioural model.
module tb_kypd_note_ctrl;

   localparam int DIV_W = 12;
   localparam int DEB   = 4;
   localparam int OM    = 3;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic [3:0]       key_value_i = 4'h0;
   logic             key_valid_i = 1'b0;
   logic             evt_ready_i = 1'b0;
   logic [DIV_W-1:0] div_factor_o;
   logic             gate_o;
   logic             noise_en_o;
   logic [2:0]       octave_o;
   logic             evt_valid_o;
   logic             evt_gate_o;
   logic [DIV_W-1:0] evt_div_o;
   logic             overrun_o;

   always #5 clk_i = ~clk_i;

   kypd_note_ctrl #(
      .DIV_W      (DIV_W),
      .DEB_CYCLES (DEB),
      .OCT_MAX    (OM)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .key_value_i  (key_value_i),
      .key_valid_i  (key_valid_i),
      .div_factor_o (div_factor_o),
      .gate_o       (gate_o),
      .noise_en_o   (noise_en_o),
      .octave_o     (octave_o),
      .evt_valid_o  (evt_valid_o),
      .evt_ready_i  (evt_ready_i),
      .evt_gate_o   (evt_gate_o),
      .evt_div_o    (evt_div_o),
      .overrun_o    (overrun_o)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   // ---------------- reference model (one step per press / release) -------
   int tbl [16] = '{0, 215, 204, 191, 171, 161, 152, 136, 128, 121, 181, 144, 114, 0, 0, 0};
   int m_oct, m_base, m_gate, m_noise, m_held, m_code;
   int exp_q[$];
   int rx_q[$];
   bit hold0;
   int pend_n, last_ev, exp_ovr, ovr_seen;

   function automatic bit is_note_m(input int c);
      return (c >= 1) && (c <= 12);
   endfunction

   function automatic int mdiv();
      int v;
      if (m_oct >= 0) return m_base >> m_oct;
      v = m_base << (-m_oct);
      return (v > (1 << DIV_W) - 1) ? (1 << DIV_W) - 1 : v;
   endfunction

   task automatic model_reset();
      m_oct = 0; m_base = 128; m_gate = 0; m_noise = 0; m_held = 0; m_code = 0;
      pend_n = 0;
   endtask

   task automatic emit(input int g, input int d);
      if (hold0) begin
         pend_n++;
         last_ev = g * 65536 + d;
      end else begin
         exp_q.push_back(g * 65536 + d);
      end
   endtask

   task automatic accept(input int c);
      m_held = 1;
      m_code = c;
      if (is_note_m(c)) begin
         m_base = tbl[c]; m_gate = 1; m_noise = 0;
         emit(1, mdiv());
      end else if (c == 13) begin
         if (m_oct > -OM) m_oct--;
      end else if (c == 14) begin
         if (m_oct < OM) m_oct++;
      end else if (c == 15) begin
         m_noise = 1 - m_noise;
      end else begin
         m_base = 128; m_noise = 1;
      end
   endtask

   // ---------------- stimulus helpers --------------------------------------
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // First cycle of each phase always accepts so events never collide.
   function automatic logic pick_rdy(input int i);
      if (hold0) return 1'b0;
      if (i == 0) return 1'b1;
      return $urandom_range(0, 3) != 0;
   endfunction

   task automatic check_outs(input string ph);
      chk({ph, "_gate"},  32'(gate_o),     m_gate);
      chk({ph, "_noise"}, 32'(noise_en_o), m_noise);
      chk({ph, "_oct"},   32'($signed(octave_o)), m_oct);
      chk({ph, "_div"},   32'(div_factor_o), mdiv());
   endtask

   task automatic press(input int code, input int p);
      for (int i = 0; i < p; i++) begin
         key_valid_i = 1'b1;
         key_value_i = 4'(code);
         evt_ready_i = pick_rdy(i);
         cyc();
      end
      if (!m_held && p >= DEB + 1) accept(code);
      check_outs("press");
   endtask

   task automatic release_key(input int r);
      for (int i = 0; i < r; i++) begin
         key_valid_i = 1'b0;
         key_value_i = 4'($urandom_range(0, 15));
         evt_ready_i = pick_rdy(i);
         cyc();
      end
      if (m_held && r >= DEB + 1) begin
         m_held = 0;
         if (is_note_m(m_code)) begin
            m_gate = 0;
            emit(0, mdiv());
         end
      end
      check_outs("release");
   endtask

   task automatic idle(input int n);
      key_valid_i = 1'b0;
      evt_ready_i = 1'b1;
      repeat (n) cyc();
   endtask

   // ---------------- output monitor ---------------------------------------
   logic             pv = 1'b0, pr = 1'b0, prst = 1'b1, pg = 1'b0;
   logic [DIV_W-1:0] pd = '0;

   always @(negedge clk_i) begin
      if (overrun_o === 1'b1) ovr_seen++;
      if (pv && !pr && !prst && !overrun_o) begin
         chk("evt_hold_valid", 32'(evt_valid_o), 1);
         chk("evt_hold_data", {evt_gate_o, evt_div_o}, {pg, pd});
      end
      if (evt_valid_o && evt_ready_i && !rst_i)
         rx_q.push_back(int'(evt_gate_o) * 65536 + int'(evt_div_o));
      pv   = evt_valid_o;
      pr   = evt_ready_i;
      prst = rst_i;
      pg   = evt_gate_o;
      pd   = evt_div_o;
   end

   // ---------------- test sequence ----------------------------------------
   initial begin
      int code, p, n;
      model_reset();
      hold0 = 0; exp_ovr = 0; ovr_seen = 0; last_ev = 0;

      rst_i = 1'b1;
      repeat (3) cyc();
      rst_i = 1'b0;
      check_outs("reset");
      chk("reset_evt_valid", 32'(evt_valid_o), 0);
      chk("reset_overrun",   32'(overrun_o),   0);

      // note on/off on key 8
      press(8, DEB + 1);
      chk("key8_gate_on", 32'(gate_o), 1);
      release_key(DEB + 1);
      chk("key8_gate_off", 32'(gate_o), 0);

      // octave up twice then key 1, then saturation at +OM
      press(14, DEB + 1); release_key(DEB + 1);
      press(14, DEB + 1); release_key(DEB + 1);
      press(1, DEB + 2);
      chk("oct_up2", 32'($signed(octave_o)), 2);
      chk("div_53",  32'(div_factor_o), 53);
      release_key(DEB + 2);
      repeat (3) begin press(14, DEB + 1); release_key(DEB + 1); end
      chk("oct_sat_hi", 32'($signed(octave_o)), OM);

      // octave down to -OM, key 1 unsaturated, one more D stays
      repeat (6) begin press(13, DEB + 1); release_key(DEB + 1); end
      press(1, DEB + 1);
      chk("div_1720", 32'(div_factor_o), 1720);
      release_key(DEB + 1);
      press(13, DEB + 1); release_key(DEB + 1);
      chk("oct_sat_lo", 32'($signed(octave_o)), -OM);
      repeat (3) begin press(14, DEB + 1); release_key(DEB + 1); end

      // glitch and debounce boundary
      press(5, 2); release_key(DEB + 1);
      press(5, DEB); release_key(DEB + 1);
      press(5, DEB + 1); release_key(DEB + 1);

      // code change while held is ignored; short release returns to held
      press(3, DEB + 1); release_key(2); press(7, DEB + 2); release_key(DEB + 1);

      // noise toggle, rest key, note clears noise
      press(15, DEB + 1); release_key(DEB + 1);
      press(15, DEB + 1); release_key(DEB + 1);
      press(0, DEB + 1);  release_key(DEB + 1);
      press(2, DEB + 1);  release_key(DEB + 1);

      // overrun with a stalled consumer, then a single drain
      idle(3);
      hold0 = 1;
      press(1, DEB + 1); release_key(DEB + 1); press(3, DEB + 1);
      chk("buf_valid", 32'(evt_valid_o), 1);
      chk("buf_latest", int'(evt_gate_o) * 65536 + int'(evt_div_o), last_ev);
      evt_ready_i = 1'b1;
      cyc();
      evt_ready_i = 1'b0;
      exp_q.push_back(last_ev);
      exp_ovr += pend_n - 1;
      pend_n = 0;
      hold0 = 0;
      chk("drain_single", 32'(evt_valid_o), 0);
      release_key(DEB + 1);

      // reset while held with an event pending
      idle(3);
      hold0 = 1;
      press(8, DEB + 1);
      rst_i = 1'b1; key_valid_i = 1'b0; evt_ready_i = 1'b0;
      cyc();
      rst_i = 1'b0;
      hold0 = 0;
      model_reset();
      check_outs("rst_held");
      chk("rst_evt_valid", 32'(evt_valid_o), 0);
      chk("rst_overrun",   32'(overrun_o),   0);
      idle(DEB + 4);

      // random key sessions
      repeat (60) begin
         code = $urandom_range(0, 15);
         p = ($urandom_range(0, 1) == 0) ? $urandom_range(1, DEB) : $urandom_range(DEB + 1, DEB + 4);
         press(code, p);
         release_key($urandom_range(DEB + 1, DEB + 4));
      end

      idle(6);
      chk("evt_count", rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk("evt_seq", rx_q[i], exp_q[i]);
      chk("overrun_count", ovr_seen, exp_ovr);
      chk("final_valid", 32'(evt_valid_o), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
